// File: rtl/expr_seq_unit.sv
// expr_seq_unit - iterative multiply / multiply-accumulate / integer square-root unit.
//
// Drop-in successor to the 8-bit `expr` start/busy block, parametrised on W.
// Host protocol: poll busy_o, pulse start_i, read y_bo after the done_o pulse.
//
// Ports:
//   clk_i    - clock; all state changes on the rising edge
//   rst_n_i  - asynchronous active-low reset
//   a_i      - operand A (unsigned), also the square-root radicand
//   b_i      - operand B (unsigned), ignored for square root
//   op_i     - 0 = MUL, 1 = MAC, 2 = SQRT (when built), 3 = reserved (runs as MUL)
//   start_i  - request, honoured only while idle
//   y_bo     - 2W-bit result register, updated only on completion or reset
//   busy_o   - high while an operation is in flight
//   done_o   - one-cycle pulse in the cycle after y_bo is updated
//
// Build option:
//   EXPR_SEQ_SQRT_EN - when defined, builds the RUN_SQRT state and the
//                      non-restoring square-root datapath (latency W/2).
//                      When undefined, op 2 runs as MUL (latency W).

module expr_seq_unit #(
  parameter int unsigned W = 8
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  logic [1:0]     op_i,
  input  logic           start_i,
  output logic [2*W-1:0] y_bo,
  output logic           busy_o,
  output logic           done_o
);

  localparam int unsigned CW = $clog2(W);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN_MUL  = 2'd1;
  localparam logic [1:0] ST_RUN_SQRT = 2'd2;

  localparam logic [1:0] OP_MAC  = 2'd1;
`ifdef EXPR_SEQ_SQRT_EN
  localparam logic [1:0] OP_SQRT = 2'd2;
  // Partial remainder width: wide enough for (rem << 2) plus the trial term
  // without losing the sign bit.
  localparam int unsigned RW = W/2 + 4;
`endif

  logic [1:0]     state_q,  state_d;
  logic [2*W-1:0] mcand_q,  mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [2*W-1:0] acc_q,    acc_d;
  logic [CW-1:0]  cnt_q,    cnt_d;
  logic [2*W-1:0] y_q,      y_d;
  logic           done_q,   done_d;
  logic [2*W-1:0] acc_nxt;

`ifdef EXPR_SEQ_SQRT_EN
  logic [W-1:0]   rad_q,    rad_d;
  logic [RW-1:0]  rem_q,    rem_d;
  logic [W/2-1:0] root_q,   root_d;
  logic [RW-1:0]  trial;
  logic [RW-1:0]  rem_nxt;
  logic [W/2-1:0] root_nxt;
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    done_d   = 1'b0;
    acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);
`ifdef EXPR_SEQ_SQRT_EN
    rad_d    = rad_q;
    rem_d    = rem_q;
    root_d   = root_q;
    // Non-restoring step: bring down two radicand bits, then subtract
    // (4*root + 1) when the remainder is non-negative, else add (4*root + 3).
    trial    = (rem_q << 2) | RW'(rad_q[W-1:W-2]);
    if (!rem_q[RW-1]) begin
      rem_nxt = trial - {{(RW-W/2-2){1'b0}}, root_q, 2'b01};
    end else begin
      rem_nxt = trial + {{(RW-W/2-2){1'b0}}, root_q, 2'b11};
    end
    root_nxt = {root_q[W/2-2:0], ~rem_nxt[RW-1]};
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mcand_d  = {{W{1'b0}}, a_i};
          mplier_d = b_i;
          // MAC seeds the accumulator with the result held before the start.
          acc_d    = (op_i == OP_MAC) ? y_q : '0;
          cnt_d    = '0;
          state_d  = ST_RUN_MUL;
`ifdef EXPR_SEQ_SQRT_EN
          if (op_i == OP_SQRT) begin
            rad_d   = a_i;
            rem_d   = '0;
            root_d  = '0;
            state_d = ST_RUN_SQRT;
          end
`endif
        end
      end

      ST_RUN_MUL: begin
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(W-1)) begin
          y_d     = acc_nxt;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

`ifdef EXPR_SEQ_SQRT_EN
      ST_RUN_SQRT: begin
        rem_d  = rem_nxt;
        root_d = root_nxt;
        rad_d  = rad_q << 2;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(W/2-1)) begin
          y_d     = {{(W + W/2){1'b0}}, root_nxt};
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      y_q      <= '0;
      done_q   <= 1'b0;
`ifdef EXPR_SEQ_SQRT_EN
      rad_q    <= '0;
      rem_q    <= '0;
      root_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      done_q   <= done_d;
`ifdef EXPR_SEQ_SQRT_EN
      rad_q    <= rad_d;
      rem_q    <= rem_d;
      root_q   <= root_d;
`endif
    end
  end

  assign y_bo   = y_q;
  assign busy_o = (state_q != ST_IDLE);
  assign done_o = done_q;

endmodule

// File: tb/tb_expr_seq_unit.sv
module tb_expr_seq_unit;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [1:0]     op;
  logic           start;
  logic [2*W-1:0] y;
  logic           busy;
  logic           done;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] model_y;

  expr_seq_unit #(.W(W)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .a_i     (a),
    .b_i     (b),
    .op_i    (op),
    .start_i (start),
    .y_bo    (y),
    .busy_o  (busy),
    .done_o  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] y;
    int             lat;
  } vec_t;

  vec_t vt[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int isqrt(input int v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Reference: result depends only on the op, operands and previous result.
  function automatic logic [2*W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] x,
                                                input logic [W-1:0] z, input logic [2*W-1:0] prev);
    int unsigned p;
    p = int'(x) * int'(z);
    case (o)
      2'd1: return (2*W)'((p + int'(prev)) % (1 << (2*W)));
`ifdef EXPR_SEQ_SQRT_EN
      2'd2: return (2*W)'(isqrt(int'(x)));
`endif
      default: return (2*W)'(p);
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] o);
`ifdef EXPR_SEQ_SQRT_EN
    if (o == 2'd2) return W/2;
`endif
    return W;
  endfunction

  // Issue one operation from a negedge, verify busy/hold/latency/result/pulse.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] z,
                        input logic [2*W-1:0] exp_y, input int exp_lat, input string tag);
    logic [2*W-1:0] y_before;
    int  n;
    bit  seen;
    bit  steady;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = z;
    y_before = y;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 2'($urandom);
    check({tag, "_busy_after_accept"}, busy, 1);
    n = 0; seen = 0; steady = 1;
    while (!seen && n < 40) begin
      if (!busy || done || y !== y_before) steady = 0;
      @(negedge clk);
      n++;
      if (done) seen = 1;
    end
    check({tag, "_timeout"}, seen, 1);
    check({tag, "_hold_while_busy"}, steady, 1);
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_result"}, y, exp_y);
    check({tag, "_busy_clear"}, busy, 0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_y = '0;
  endtask

  initial begin
    int dcnt;
    logic [2*W-1:0] y_at_done;
    int n;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; op = '0;
    model_y = '0;
    #3;
    check("reset_y", y, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed table, expected values written out by hand.
    vt[0] = '{2'd0, 8'hFF, 8'hFF, 16'hFE01, 8};
    vt[1] = '{2'd0, 8'h00, 8'hFF, 16'h0000, 8};
    vt[2] = '{2'd0, 8'h03, 8'h04, 16'h000C, 8};
    vt[3] = '{2'd1, 8'h05, 8'h06, 16'h002A, 8};
    vt[4] = '{2'd1, 8'h00, 8'h09, 16'h002A, 8};
    vt[5] = '{2'd0, 8'hFF, 8'hFF, 16'hFE01, 8};
    vt[6] = '{2'd1, 8'hFF, 8'hFF, 16'hFC02, 8};
    vt[7] = '{2'd3, 8'h03, 8'h05, 16'h000F, 8};
`ifdef EXPR_SEQ_SQRT_EN
    vt[8]  = '{2'd2, 8'd200, 8'h00, 16'h000E, 4};
    vt[9]  = '{2'd2, 8'hFF,  8'h33, 16'h000F, 4};
    vt[10] = '{2'd2, 8'h00,  8'h77, 16'h0000, 4};
`else
    vt[8]  = '{2'd2, 8'd200, 8'h02, 16'h0190, 8};
    vt[9]  = '{2'd2, 8'hFF,  8'h01, 16'h00FF, 8};
    vt[10] = '{2'd2, 8'h00,  8'h05, 16'h0000, 8};
`endif
    for (int i = 0; i < 11; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].y, vt[i].lat, $sformatf("vec%0d", i));
    end
    model_y = vt[10].y;

    // Start while busy: second request at T0+3 must be dropped.
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 8'h12; b = 8'h34;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0; y_at_done = '0;
    repeat (20) begin
      @(negedge clk);
      if (done) begin dcnt++; y_at_done = y; end
    end
    check("busy_ignore_done_count", dcnt, 1);
    check("busy_ignore_result", y_at_done, 16'h03A8);
    check("busy_ignore_idle", busy, 0);
    model_y = 16'h03A8;

    // Back-to-back: start held high through completion; accepted after done cycle.
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 8'h03; b = 8'h04;
    repeat (3) @(negedge clk);
    a = 8'h05; b = 8'h06;
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    check("b2b_first_result", y, 16'h000C);
    check("b2b_busy_in_done_cycle", busy, 0);
    @(negedge clk);
    start = 1'b0;
    check("b2b_second_accepted", busy, 1);
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    check("b2b_second_latency", n, W);
    check("b2b_second_result", y, 16'h001E);
    model_y = 16'h001E;

    // Reset mid-operation aborts; first MAC afterwards accumulates onto 0.
    @(negedge clk);
    start = 1'b1; op = 2'd1; a = 8'h07; b = 8'h07;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_y_zero", y, 0);
    check("abort_busy_zero", busy, 0);
    check("abort_done_zero", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_y = '0;
    dcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    run_op(2'd1, 8'h02, 8'h03, 16'h0006, W, "post_reset_mac");
    model_y = 16'h0006;

    // Start on the first edge after reset release.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1; op = 2'd1; a = 8'h09; b = 8'h0B;
    @(negedge clk);
    start = 1'b0;
    check("release_accept", busy, 1);
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    check("release_result", y, 16'h0063);
    model_y = 16'h0063;

    // Randomized operations against the reference model.
    for (int i = 0; i < 250; i++) begin
      logic [1:0]     ro;
      logic [W-1:0]   ra;
      logic [W-1:0]   rb;
      logic [2*W-1:0] ey;
      ro = 2'($urandom_range(0, 3));
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 17 == 0) ra = '1;
      if (i % 19 == 0) rb = '0;
      ey = ref_result(ro, ra, rb, model_y);
      run_op(ro, ra, rb, ey, ref_latency(ro), $sformatf("rnd%0d_op%0d", i, ro));
      model_y = ey;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/expr_seq_unit.md
# expr_seq_unit

Parametrised iterative arithmetic unit and successor to the fixed 8-bit `expr` start/busy block. It runs on the datapath clock and accepts one W-bit operand pair per start pulse. It computes a product, a multiply-accumulate, or an integer square root (optional) with a shift-add / digit-by-digit engine, and returns a 2W-bit result with a busy/done handshake. The host drives it the same way as `expr`: poll `busy_o`, pulse `start_i`, read `y_bo`.

## Interface
- `W`, default 8: operand width; must be even and ≥ 4; result width is 2W.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_n_i`  in  1  reset; asynchronous, active-low.
- `a_i`  in  W  operand A (unsigned); also the square-root radicand.
- `b_i`  in  W  operand B (unsigned); ignored for square root.
- `op_i`  in  2  operation: 0 = MUL, 1 = MAC, 2 = SQRT (with macro), 3 = reserved.
- `start_i`  in  1  request; sampled on the rising edge.
- `y_bo`  out  2W  result register.
- `busy_o`  out  1  high while an operation is in flight.
- `done_o`  out  1  one-cycle pulse when `y_bo` is updated.

## Operation
- States: IDLE, RUN_MUL, RUN_SQRT.
- Accept rule: in IDLE, `start_i`=1 at a rising edge latches `a_i`, `b_i` and `op_i`.
  - MUL/MAC → RUN_MUL.
  - SQRT → RUN_SQRT.
  - `busy_o` goes to 1 on the same edge.
- `start_i` while `busy_o`=1 is ignored: no queueing and no effect on the running operation.
- RUN_MUL: radix-2 shift-add, one multiplier bit per cycle, LSB first, exactly W iterations.
  - MUL: `y_bo` ← A·B.
  - MAC: `y_bo` ← A·B + `y_bo` (the value held before the start), truncated mod 2^(2W). No overflow flag.
- RUN_SQRT: non-restoring digit-by-digit method, 2 radicand bits per cycle, exactly W/2 iterations.
  - `y_bo` ← floor(sqrt(A)), zero-extended to 2W.
- Op 3, and op 2 when the macro is absent, execute as MUL with identical timing.
- Completion, on the final iteration edge:
  - `y_bo` is written.
  - `busy_o` ← 0.
  - `done_o` ← 1 for exactly one cycle.
  - The state returns to IDLE.
- `y_bo` holds its value between operations. It changes only on completion or reset. Intermediate partial products never appear on `y_bo`.
- Reset values (asynchronous, while `rst_n_i`=0): `y_bo`=0, `busy_o`=0, `done_o`=0, state=IDLE, internal registers cleared.
- Reset mid-operation aborts the operation. After release the unit is in IDLE; the first accepted MAC accumulates onto 0.

## Timing
- Start accepted at edge T0.
- MUL/MAC: `busy_o`=1 from T0 to T0+W. The result and `done_o` are visible after edge T0+W.
- SQRT: the same, with W/2 in place of W.
- Back-to-back: `start_i` held high in the `done_o` cycle is accepted on the next edge. Minimum issue interval is W+1 cycles for MUL/MAC and W/2+1 for SQRT.
- `start_i` high at the completion edge itself is not accepted, because `busy_o` is still 1 at that edge.
- Operand inputs only need to be stable at the accepting edge.
- Reset release: the first edge with `rst_n_i`=1 can accept a start.

## Configuration
- `EXPR_SEQ_SQRT_EN` defined:
  - RUN_SQRT state and its datapath are built.
  - op 2 = integer square root, latency W/2.
- `EXPR_SEQ_SQRT_EN` undefined:
  - No square-root logic is built.
  - op 2 behaves exactly as MUL: W cycles, result A·B.

## Test plan
- W=8, MUL, a=0xFF, b=0xFF → `busy_o` high 8 cycles; `y_bo`=0xFE01 with `done_o` pulse after edge T0+8. Also a=0, b=0xFF → 0x0000.
- MAC chain after reset: MUL 3×4 → 0x000C; MAC 5×6 → 0x002A; MAC 0×9 → 0x002A.
- MAC wrap: MUL 0xFF×0xFF → 0xFE01; MAC 0xFF×0xFF → 0xFC02, i.e. 0x1FC02 mod 2^16.
- SQRT with macro, a=200 → `y_bo`=0x000E after 4 cycles. a=0xFF → 0x000F; a=0 → 0.
  - Without the macro, op 2 with a=200, b=2 → 0x0190 after 8 cycles.
- Start while busy: MUL 0x12×0x34 issued; `start_i` pulsed at T0+3 with a=b=0xFF → single result 0x03A8, exactly one `done_o`, second request dropped.
- Reset mid-op: start MAC 7×7; drive `rst_n_i`=0 at T0+4 → outputs 0 immediately, no `done_o`. After release, MAC 2×3 → 0x0006.
